mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 62 ++++++
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access_load_align.sv | 31 +++
 rtl/mem_access.sv | 154 +++++++++++++++
 tb/tb_mem_access.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage memory access block: size codes, FSM states,
// the captured request record and the store lane helpers.
package mem_access_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic [1:0]      offset;
    logic            we;
    logic            is_load;
    size_e           size;
    logic            unsigned_ld;
  } req_t;

  function automatic logic misaligned(size_e sz, logic [1:0] ofs);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = ofs[0];
      default: bad = (ofs != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(size_e sz, logic [1:0] ofs);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << ofs;
      SZ_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] lane_data(size_e sz, logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface mem_access_if;
  import mem_access_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Load formatter: picks the byte/half lane out of a read word and extends it.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  size_e           size,
  input  logic            unsigned_ld,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: result_c = {{24{~unsigned_ld & byte_lane[7]}}, byte_lane};
      SZ_HALF: result_c = {{16{~unsigned_ld & half_lane[15]}}, half_lane};
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes ALU results through and runs one stalled, bounded memory
// transaction (IDLE -> BUSY -> DONE) per load or store.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  aluresult,
  input  logic [XLEN-1:0]  writedata,
  input  logic [4:0]       rd,
  input  logic             Regwrite,
  input  logic             MemtoReg,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [1:0]       size,
  input  logic             unsigned_ld,
  mem_access_if.master     bus,
  output logic [XLEN-1:0]  aluresultout,
  output logic [XLEN-1:0]  memreadresultout,
  output logic [4:0]       rdout,
  output logic             Regwriteout,
  output logic             MemtoRegout,
  output logic             stall,
  output logic             misalign,
  output logic             bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e          state;
  state_e          state_nxt;
  req_t            req_q;
  req_t            req_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [XLEN-1:0] result_q;
  logic            aborted_q;
  logic [XLEN-1:0] load_val;
  size_e           size_in;
  logic            mem_op;
  logic            mis;
  logic            timeout_hit;

  assign size_in     = size_e'(size);
  assign mem_op      = MemRead | MemWrite;
  assign mis         = misaligned(size_in, aluresult[1:0]);
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  // Request snapshot; a simultaneous read+write is handled as a store.
  always_comb begin
    req_d             = '0;
    req_d.addr        = {aluresult[XLEN-1:2], 2'b00};
    req_d.wdata       = lane_data(size_in, writedata);
    req_d.be          = lane_be(size_in, aluresult[1:0]);
    req_d.offset      = aluresult[1:0];
    req_d.we          = MemWrite;
    req_d.is_load     = MemRead & ~MemWrite;
    req_d.size        = size_in;
    req_d.unsigned_ld = unsigned_ld;
  end

  mem_access_load_align u_load_align (
    .rdata       (bus.mem_rdata),
    .offset      (req_q.offset),
    .size        (req_q.size),
    .unsigned_ld (req_q.unsigned_ld),
    .result_c    (load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mem_op && !mis) state_nxt = ST_BUSY;
      ST_BUSY: if (bus.mem_ack || timeout_hit) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Captured request, timeout counter and the result handed to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      cnt       <= '0;
      result_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (mem_op && !mis) begin
            req_q     <= req_d;
            result_q  <= '0;
            aborted_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          cnt <= cnt_inc;
          if (bus.mem_ack) begin
            result_q <= req_q.is_load ? load_val : '0;
          end else if (timeout_hit) begin
            result_q  <= '0;
            aborted_q <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    aluresultout     = aluresult;
    rdout            = rd;
    MemtoRegout      = MemtoReg;
    Regwriteout      = Regwrite;
    memreadresultout = '0;
    stall            = 1'b0;
    misalign         = 1'b0;
    bus_error        = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = req_q.addr;
    bus.mem_wdata    = req_q.wdata;
    bus.mem_be       = req_q.be;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          Regwriteout = 1'b0;
          misalign    = mis;
          stall       = ~mis;
        end
      end
      ST_BUSY: begin
        stall       = 1'b1;
        Regwriteout = 1'b0;
        bus.mem_req = 1'b1;
        bus.mem_we  = req_q.we;
        bus_error   = ~bus.mem_ack & timeout_hit;
      end
      default: begin
        memreadresultout = result_q;
        Regwriteout      = Regwrite & ~aborted_q;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table, directed corner sequences
// and random traffic against a behavioural model of the stage.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] aluresult, writedata;
  logic [4:0]  rd;
  logic        Regwrite, MemtoReg, MemRead, MemWrite;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] aluresultout, memreadresultout;
  logic [4:0]  rdout;
  logic        Regwriteout, MemtoRegout, stall, misalign, bus_error;

  int total = 0;
  int bad   = 0;

  mem_access_if bus();

  mem_access #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .aluresult        (aluresult),
    .writedata        (writedata),
    .rd               (rd),
    .Regwrite         (Regwrite),
    .MemtoReg         (MemtoReg),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .size             (size),
    .unsigned_ld      (unsigned_ld),
    .bus              (bus),
    .aluresultout     (aluresultout),
    .memreadresultout (memreadresultout),
    .rdout            (rdout),
    .Regwriteout      (Regwriteout),
    .MemtoRegout      (MemtoRegout),
    .stall            (stall),
    .misalign         (misalign),
    .bus_error        (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  r;
    logic        rw, m2r, mr, mw;
    logic [1:0]  sz;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_rw, e_stall, e_mis;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                       input logic rw, input logic m2r, input logic mr, input logic mw,
                       input logic [1:0] sz, input logic u);
    aluresult = a; writedata = wd; rd = r; Regwrite = rw; MemtoReg = m2r;
    MemRead = mr; MemWrite = mw; size = sz; unsigned_ld = u;
  endtask

  // Behavioural reference: address rules and lane arithmetic.
  function automatic bit ref_misaligned(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, int off, logic [1:0] sz, logic u);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!u && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(logic [1:0] sz, int off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdata(logic [1:0] sz, logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // Runs one aligned memory op whose inputs were just driven; ack arrives in
  // BUSY cycle ack_at (0 = never). Ends sampled in the completion cycle.
  task automatic run_txn(input string nm, input int ack_at, input logic [31:0] rdat);
    int          off, e_reqs, e_berr_at, reqs, stalls, berr_at;
    bit          is_st, acked, done;
    logic [31:0] e_res;
    logic        e_regw;
    off       = int'(aluresult % 4);
    is_st     = MemWrite;
    acked     = (ack_at >= 1) && (ack_at <= TO);
    e_reqs    = acked ? ack_at : TO;
    e_berr_at = acked ? -1 : TO;
    e_res     = (!acked || is_st) ? 32'h0 : ref_load(rdat, off, size, unsigned_ld);
    e_regw    = acked ? Regwrite : 1'b0;
    reqs = 0; stalls = 0; berr_at = -1; done = 0;
    #2;
    chk({nm, " issue stall"}, 32'(stall), 32'd1);
    chk({nm, " issue req"}, 32'(bus.mem_req), 32'd0);
    chk({nm, " issue regw"}, 32'(Regwriteout), 32'd0);
    if (stall) stalls = 1;
    for (int k = 1; k <= 30 && !done; k++) begin
      step();
      bus.mem_ack   = (k == ack_at);
      bus.mem_rdata = rdat;
      #2;
      if (stall) begin
        stalls++;
        if (bus.mem_req) reqs++;
        if (bus_error) berr_at = k;
        chk({nm, " busy regw"}, 32'(Regwriteout), 32'd0);
        chk({nm, " addr"}, bus.mem_addr, aluresult & 32'hFFFF_FFFC);
        chk({nm, " we"}, 32'(bus.mem_we), 32'(is_st));
        if (is_st) begin
          chk({nm, " be"}, 32'(bus.mem_be), 32'(ref_be(size, off)));
          chk({nm, " wdata"}, bus.mem_wdata, ref_wdata(size, writedata));
        end
      end else begin
        done = 1;
        chk({nm, " done req"}, 32'(bus.mem_req), 32'd0);
        chk({nm, " result"}, memreadresultout, e_res);
        chk({nm, " done regw"}, 32'(Regwriteout), 32'(e_regw));
        chk({nm, " done rd"}, 32'(rdout), 32'(rd));
        chk({nm, " stall cycles"}, 32'(stalls), 32'(1 + e_reqs));
        chk({nm, " req cycles"}, 32'(reqs), 32'(e_reqs));
        chk({nm, " bus_error cycle"}, 32'(berr_at), 32'(e_berr_at));
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s: stall never released within 30 cycles", nm);
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    vec_t        tbl [8];
    logic [31:0] a;
    logic [1:0]  sz;
    logic        rw, m2r, u;
    int          op;

    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    #1 rst = 1'b1;
    repeat (2) step();
    drive(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    chk("reset req", 32'(bus.mem_req), 32'd0);
    chk("reset misalign", 32'(misalign), 32'd0);
    chk("reset bus_error", 32'(bus_error), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset addr", bus.mem_addr, 32'h0);
    step();
    rst = 1'b0;

    tbl[0] = '{32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_0101, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0101, 5'd7,  1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0103, 5'd8,  1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_0103, 5'd8,  1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'h0000_0102, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_0102, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[6] = '{32'h0000_0206, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0000_0206, 5'd9,  1'b0, 1'b0, 1'b1};
    tbl[7] = '{32'hDEAD_BEEF, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF, 5'd12, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].alu, 32'hA5A5_A5A5, tbl[i].r, tbl[i].rw, tbl[i].m2r, tbl[i].mr, tbl[i].mw, tbl[i].sz, 1'b0);
      bus.mem_ack = 1'($urandom_range(0, 1));
      #2;
      if (!(tbl[i].mr || tbl[i].mw)) begin
        chk($sformatf("vec%0d alu", i), aluresultout, tbl[i].e_alu);
        chk($sformatf("vec%0d rd", i), 32'(rdout), 32'(tbl[i].e_rd));
      end
      chk($sformatf("vec%0d regw", i), 32'(Regwriteout), 32'(tbl[i].e_rw));
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
      chk($sformatf("vec%0d req", i), 32'(bus.mem_req), 32'd0);
      step();
    end
    bus.mem_ack = 1'b0;

    // Signed byte load from the top lane, ack in the second BUSY cycle.
    drive(32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    run_txn("lb_0x103", 2, 32'h8012_3456);
    chk("lb_0x103 value", memreadresultout, 32'hFFFF_FF80);
    step();

    drive(32'h0000_0102, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    run_txn("sh_0x102", 1, 32'h1111_2222);
    step();

    // No ack: abort after TO BUSY cycles, then back to pass-through.
    drive(32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    run_txn("lw_timeout", 0, 32'hCAFE_F00D);
    step();
    drive(32'h0000_0777, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    chk("post_abort stall", 32'(stall), 32'd0);
    chk("post_abort alu", aluresultout, 32'h0000_0777);
    step();

    // Reset in the middle of BUSY, then a fresh load.
    drive(32'h0000_0200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    step();
    #2;
    chk("midbusy req before rst", 32'(bus.mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midbusy req after rst", 32'(bus.mem_req), 32'd0);
    chk("midbusy bus_error", 32'(bus_error), 32'd0);
    MemRead = 1'b0;
    step();
    rst = 1'b0;
    #2;
    chk("no replay req", 32'(bus.mem_req), 32'd0);
    chk("no replay stall", 32'(stall), 32'd0);
    step();
    drive(32'h0000_0204, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    run_txn("lw_after_rst", 1, 32'h1357_9BDF);
    step();

    for (int n = 0; n < 80; n++) begin
      op  = int'($urandom_range(0, 3));
      a   = $urandom;
      sz  = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));
      u   = 1'($urandom_range(0, 1));
      drive(a, $urandom, 5'($urandom), rw, m2r, (op == 1) || (op == 3), op >= 2, sz, u);
      bus.mem_ack = 1'($urandom_range(0, 1));
      if (op == 0) begin
        #2;
        chk($sformatf("rnd%0d alu", n), aluresultout, a);
        chk($sformatf("rnd%0d regw", n), 32'(Regwriteout), 32'(rw));
        chk($sformatf("rnd%0d m2r", n), 32'(MemtoRegout), 32'(m2r));
        chk($sformatf("rnd%0d stall", n), 32'(stall), 32'd0);
        chk($sformatf("rnd%0d memres", n), memreadresultout, 32'h0);
      end else if (ref_misaligned(sz, a)) begin
        #2;
        chk($sformatf("rnd%0d misalign", n), 32'(misalign), 32'd1);
        chk($sformatf("rnd%0d mis stall", n), 32'(stall), 32'd0);
        chk($sformatf("rnd%0d mis regw", n), 32'(Regwriteout), 32'd0);
        chk($sformatf("rnd%0d mis req", n), 32'(bus.mem_req), 32'd0);
      end else begin
        run_txn($sformatf("rnd%0d", n), int'($urandom_range(0, 6)), $urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
